// File: rtl/em_counter_mod.sv
// rtl/em_counter_mod.sv - presettable up/down modulus counter with terminal-count and load-range flags
module em_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             nclr,
    input  logic             nload,
    input  logic             ent,
    input  logic             enp,
    input  logic             up,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] count,
    output logic             rco,
    output logic             tc_pulse,
    output logic             range_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             load_legal;
    logic             at_top;
    logic             at_bottom;
    logic             wrap;
    logic [WIDTH-1:0] count_step;

    assign load_legal = ({1'b0, parallel_in} < MOD_EXT);
    assign at_top     = (count == MAX_VAL);
    assign at_bottom  = (count == '0);
    assign wrap       = up ? at_top : at_bottom;

    // rco follows ent and up without waiting for an edge, so cascaded stages settle in one cycle.
    assign rco = ent & wrap;

    always_comb begin
        count_step = count;
        if (up) begin
            count_step = at_top ? '0 : count + 1'b1;
        end else begin
            count_step = at_bottom ? MAX_VAL : count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nclr) begin
            count     <= '0;
            tc_pulse  <= 1'b0;
            range_err <= 1'b0;
        end else if (!nload) begin
            count     <= load_legal ? parallel_in : MAX_VAL;
            range_err <= ~load_legal;
            tc_pulse  <= 1'b0;
        end else if (ent && enp) begin
            count    <= count_step;
            tc_pulse <= wrap;
        end else begin
            tc_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_em_counter_mod.sv
// tb/tb_em_counter_mod.sv - scoreboard bench for em_counter_mod (mod-10, mod-256, cascaded mod-16)
module tb_em_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       a_nclr, a_nload, a_ent, a_enp, a_up, a_rco, a_tc, a_err;
    logic [3:0] a_pin, a_count;

    em_counter_mod #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .nclr(a_nclr), .nload(a_nload), .ent(a_ent), .enp(a_enp), .up(a_up),
        .parallel_in(a_pin), .count(a_count), .rco(a_rco), .tc_pulse(a_tc), .range_err(a_err)
    );

    logic       b_nclr, b_nload, b_ent, b_enp, b_up, b_rco, b_tc, b_err;
    logic [7:0] b_pin, b_count;

    em_counter_mod #(.WIDTH(8), .MODULUS(256)) dut_b (
        .clk(clk), .nclr(b_nclr), .nload(b_nload), .ent(b_ent), .enp(b_enp), .up(b_up),
        .parallel_in(b_pin), .count(b_count), .rco(b_rco), .tc_pulse(b_tc), .range_err(b_err)
    );

    logic       c_nclr, c_nload, c_ent, c_enp, c_up;
    logic [3:0] c0_pin, c1_pin, c0_count, c1_count;
    logic       c0_rco, c1_rco, c0_tc, c1_tc, c0_err, c1_err;

    em_counter_mod #(.WIDTH(4), .MODULUS(16)) dut_c0 (
        .clk(clk), .nclr(c_nclr), .nload(c_nload), .ent(c_ent), .enp(c_enp), .up(c_up),
        .parallel_in(c0_pin), .count(c0_count), .rco(c0_rco), .tc_pulse(c0_tc), .range_err(c0_err)
    );

    em_counter_mod #(.WIDTH(4), .MODULUS(16)) dut_c1 (
        .clk(clk), .nclr(c_nclr), .nload(c_nload), .ent(c0_rco), .enp(c_enp), .up(c_up),
        .parallel_in(c1_pin), .count(c1_count), .rco(c1_rco), .tc_pulse(c1_tc), .range_err(c1_err)
    );

    typedef struct {
        logic [7:0] count;
        logic       tc;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   m_count;
    bit   m_tc;
    bit   m_err;

    // Drive dut_a, advance the mod-10 reference model, queue the expectation, clock once.
    task automatic step_a(input bit nclr, input bit nload, input bit ent, input bit enp,
                          input bit up, input int pin);
        exp_t e;
        a_nclr = nclr; a_nload = nload; a_ent = ent; a_enp = enp; a_up = up; a_pin = 4'(pin);
        if (!nclr) begin
            m_count = 0; m_tc = 0; m_err = 0;
        end else if (!nload) begin
            m_tc = 0;
            if (pin < 10) begin m_count = pin; m_err = 0; end
            else          begin m_count = 9;   m_err = 1; end
        end else if (ent && enp) begin
            if (up) begin
                m_tc    = (m_count == 9);
                m_count = (m_count == 9) ? 0 : m_count + 1;
            end else begin
                m_tc    = (m_count == 0);
                m_count = (m_count == 0) ? 9 : m_count - 1;
            end
        end else begin
            m_tc = 0;
        end
        e.count = 8'(m_count); e.tc = m_tc; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic bit rco_model();
        return a_ent && (a_up ? (m_count == 9) : (m_count == 0));
    endfunction

    task automatic test_reset();
        exp_t e;
        step_a(0, 1, 0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if ({a_count, a_tc, a_err} !== {e.count[3:0], e.tc, e.err}) begin
            bad++; $display("FAIL reset_init: got %h/%b/%b want %h/%b/%b", a_count, a_tc, a_err, e.count[3:0], e.tc, e.err);
        end
        step_a(1, 0, 0, 0, 1, 7);
        e = sb.pop_front(); total++;
        if ({a_count, a_tc, a_err} !== {e.count[3:0], e.tc, e.err}) begin
            bad++; $display("FAIL load7: got %h/%b/%b want %h/%b/%b", a_count, a_tc, a_err, e.count[3:0], e.tc, e.err);
        end
        step_a(0, 1, 1, 1, 1, 0);
        e = sb.pop_front(); total++;
        if ({a_count, a_tc, a_err} !== {4'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_from7: got %h/%b/%b want 0/0/0", a_count, a_tc, a_err);
        end
    endtask

    task automatic test_count_up();
        exp_t e;
        step_a(0, 1, 0, 0, 1, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 9; i++) begin
            step_a(1, 1, 1, 1, 1, 0);
            e = sb.pop_front(); total++;
            if ({a_count, a_tc, a_err} !== {e.count[3:0], e.tc, e.err}) begin
                bad++; $display("FAIL up_step%0d: got %h/%b/%b want %h/%b/%b", i, a_count, a_tc, a_err, e.count[3:0], e.tc, e.err);
            end
        end
        total++;
        if (a_rco !== 1'b1 || a_rco !== rco_model()) begin
            bad++; $display("FAIL rco_at9: got %b want 1", a_rco);
        end
        for (int i = 0; i < 2; i++) begin
            step_a(1, 1, 1, 1, 1, 0);
            e = sb.pop_front(); total++;
            if ({a_count, a_tc} !== {e.count[3:0], e.tc}) begin
                bad++; $display("FAIL wrap_up%0d: got %h/%b want %h/%b", i, a_count, a_tc, e.count[3:0], e.tc);
            end
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        step_a(0, 1, 0, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            step_a(1, 1, 1, 1, 0, 0);
            e = sb.pop_front(); total++;
            if ({a_count, a_tc, a_rco} !== {e.count[3:0], e.tc, rco_model()}) begin
                bad++; $display("FAIL down%0d: got %h/%b/%b want %h/%b/%b", i, a_count, a_tc, a_rco, e.count[3:0], e.tc, rco_model());
            end
        end
        step_a(1, 0, 1, 1, 0, 5);
        void'(sb.pop_front());
        step_a(1, 1, 1, 1, 1, 0);
        e = sb.pop_front(); total++;
        if (a_count !== e.count[3:0]) begin
            bad++; $display("FAIL dir_change: got %h want %h", a_count, e.count[3:0]);
        end
    endtask

    task automatic test_range();
        exp_t e;
        int   pins[4] = '{12, -1, -1, 3};
        for (int i = 0; i < 4; i++) begin
            if (pins[i] < 0) step_a(1, 1, 1, 1, 1, 0);
            else             step_a(1, 0, 1, 1, 1, pins[i]);
            e = sb.pop_front(); total++;
            if ({a_count, a_tc, a_err} !== {e.count[3:0], e.tc, e.err}) begin
                bad++; $display("FAIL range%0d: got %h/%b/%b want %h/%b/%b", i, a_count, a_tc, a_err, e.count[3:0], e.tc, e.err);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        step_a(1, 0, 1, 1, 1, 4);
        e = sb.pop_front(); total++;
        if (a_count !== e.count[3:0]) begin
            bad++; $display("FAIL load_over_count: got %h want %h", a_count, e.count[3:0]);
        end
        step_a(0, 0, 1, 1, 1, 6);
        e = sb.pop_front(); total++;
        if ({a_count, a_err} !== {e.count[3:0], e.err}) begin
            bad++; $display("FAIL clr_over_load: got %h/%b want %h/%b", a_count, a_err, e.count[3:0], e.err);
        end
        step_a(1, 1, 1, 0, 0, 0);
        e = sb.pop_front(); total++;
        if ({a_count, a_rco} !== {e.count[3:0], rco_model()}) begin
            bad++; $display("FAIL hold_enp: got %h/%b want %h/%b", a_count, a_rco, e.count[3:0], rco_model());
        end
        a_ent = 1'b0;
        #1;
        total++;
        if (a_rco !== rco_model()) begin
            bad++; $display("FAIL rco_ent0: got %b want %b", a_rco, rco_model());
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            step_a(($urandom_range(0, 19) != 0), ($urandom_range(0, 5) != 0), 1'($urandom),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
            e = sb.pop_front(); total++;
            if ({a_count, a_tc, a_err, a_rco} !== {e.count[3:0], e.tc, e.err, rco_model()}) begin
                bad++; $display("FAIL random%0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, a_count, a_tc, a_err, a_rco, e.count[3:0], e.tc, e.err, rco_model());
            end
        end
    endtask

    task automatic test_wide_and_cascade();
        exp_t e;
        b_nclr = 1; b_nload = 0; b_pin = 8'hFF; b_ent = 1; b_enp = 1; b_up = 1;
        c_nclr = 1; c_nload = 0; c0_pin = 4'hF; c1_pin = 4'h0; c_ent = 1; c_enp = 1; c_up = 1;
        sb.push_back('{8'hFF, 1'b0, 1'b0});
        sb.push_back('{8'h0F, 1'b0, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front(); total++;
        if ({b_count, b_tc, b_err, b_rco} !== {e.count, e.tc, e.err, 1'b1}) begin
            bad++; $display("FAIL w8_load255: got %h/%b/%b/%b want %h/%b/%b/1", b_count, b_tc, b_err, b_rco, e.count, e.tc, e.err);
        end
        e = sb.pop_front(); total++;
        if ({c1_count, c0_count} !== e.count) begin
            bad++; $display("FAIL casc_load: got %h want %h", {c1_count, c0_count}, e.count);
        end
        b_nload = 0 ? 1'b0 : 1'b1; c_nload = 1'b1;
        sb.push_back('{8'h00, 1'b1, 1'b0});
        sb.push_back('{8'h10, 1'b1, 1'b0});
        @(posedge clk); #1;
        e = sb.pop_front(); total++;
        if ({b_count, b_tc, b_err} !== {e.count, e.tc, e.err}) begin
            bad++; $display("FAIL w8_wrap: got %h/%b/%b want %h/%b/%b", b_count, b_tc, b_err, e.count, e.tc, e.err);
        end
        e = sb.pop_front(); total++;
        if ({c1_count, c0_count, c0_tc, c1_tc} !== {e.count, e.tc, 1'b0}) begin
            bad++; $display("FAIL casc_step: got %h/%b/%b want %h/%b/0", {c1_count, c0_count}, c0_tc, c1_tc, e.count, e.tc);
        end
    endtask

    initial begin
        a_nclr = 0; a_nload = 1; a_ent = 0; a_enp = 0; a_up = 1; a_pin = '0;
        b_nclr = 0; b_nload = 1; b_ent = 0; b_enp = 0; b_up = 1; b_pin = '0;
        c_nclr = 0; c_nload = 1; c_ent = 0; c_enp = 0; c_up = 1; c0_pin = '0; c1_pin = '0;
        m_count = 0; m_tc = 0; m_err = 0;
        @(posedge clk); #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_range();
        test_priority();
        test_back_to_back();
        test_wide_and_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
